// File: rtl/display_scan_decoder.sv
// display_scan_decoder: readback checker for a multiplexed 7-segment bus.
// Recovers per-digit BCD, decimal point and a frame tick after debounce.
module display_scan_decoder #(
  parameter int N_DIGITS      = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  input  logic                  err_clr,
  output logic [4*N_DIGITS-1:0] num_out,
  output logic [N_DIGITS-1:0]   num_valid,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic                  pattern_err,
  output logic                  frame_tick
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  logic [7:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [N_DIGITS+7:0]   prev_q;
  logic [CW-1:0]         cnt;
  logic [N_DIGITS-1:0]   mask;
  logic [N_DIGITS-1:0]   low;
  logic [N_DIGITS-1:0]   mask_nxt;
  logic [3:0]            code;
  logic                  code_ok;
  logic                  sel_ok;
  logic                  same;
  logic                  commit;

  assign low      = ~an_q;
  assign sel_ok   = $onehot(low);
  assign same     = ({an_q, seg_q} == prev_q);
  assign commit   = same && sel_ok && (cnt == CNT_PRE);
  assign mask_nxt = mask | low;

  // Segment pattern to digit; dp bit plays no part in the code.
  always_comb begin
    code    = 4'hF;
    code_ok = 1'b1;
    case (seg_q[7:1])
      7'h01:   code = 4'd0;
      7'h4F:   code = 4'd1;
      7'h12:   code = 4'd2;
      7'h06:   code = 4'd3;
      7'h4C:   code = 4'd4;
      7'h24:   code = 4'd5;
      7'h20:   code = 4'd6;
      7'h0F:   code = 4'd7;
      7'h00:   code = 4'd8;
      7'h0C:   code = 4'd9;
      7'h7F:   code = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  // Input staging plus one-deep history for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= '0;
      an_q   <= '0;
      prev_q <= '0;
    end else begin
      seg_q  <= seg_in;
      an_q   <= an_in;
      prev_q <= {an_q, seg_q};
    end
  end

  // Saturating run length of identical legal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (same && sel_ok) begin
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
    end else begin
      cnt <= sel_ok ? CW'(1) : '0;
    end
  end

  // Commit decoded digits, track the frame mask, keep the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_out     <= '0;
      num_valid   <= '0;
      dp_out      <= '0;
      mask        <= '0;
      frame_tick  <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (commit && code_ok) begin
        if (&mask_nxt) begin
          mask       <= '0;
          frame_tick <= 1'b1;
        end else begin
          mask <= mask_nxt;
        end
      end
      for (int i = 0; i < N_DIGITS; i++) begin
        if (commit && code_ok && low[i]) begin
          num_out[4*i +: 4] <= code;
          dp_out[i]         <= ~seg_q[0];
          num_valid[i]      <= 1'b1;
        end
      end
      if (commit && !code_ok) pattern_err <= 1'b1;
      else if (err_clr)       pattern_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
// tb_display_scan_decoder: directed scan sequences with a scoreboard
// of expected output events checked by an independent monitor.
module tb_display_scan_decoder;

  typedef struct {
    int         cyc;
    logic [7:0] num;
    logic [1:0] valid;
    logic [1:0] dp;
    logic       err;
    logic       tick;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [1:0]  an_in;
  logic        err_clr;
  logic [7:0]  num_out;
  logic [1:0]  num_valid;
  logic [1:0]  dp_out;
  logic        pattern_err;
  logic        frame_tick;
  logic [13:0] outs;
  logic [12:0] cur;
  logic [12:0] last = '0;
  logic        mon_en;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  obs_t        sb[$];
  obs_t        e;

  display_scan_decoder #(
    .N_DIGITS(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .an_in(an_in),
    .err_clr(err_clr),
    .num_out(num_out),
    .num_valid(num_valid),
    .dp_out(dp_out),
    .pattern_err(pattern_err),
    .frame_tick(frame_tick)
  );

  assign outs = {num_out, num_valid, dp_out, pattern_err, frame_tick};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cur = {num_out, num_valid, dp_out, pattern_err};
    if (mon_en && (cur != last || frame_tick)) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected cyc=%0d got num=%h valid=%b dp=%b err=%b tick=%b required no event",
                 cyc, num_out, num_valid, dp_out, pattern_err, frame_tick);
      end else begin
        e = sb.pop_front();
        if (e.cyc == cyc && e.num == num_out && e.valid == num_valid &&
            e.dp == dp_out && e.err == pattern_err && e.tick == frame_tick) begin
          n_pass++;
        end else begin
          $display("FAIL sb_event got cyc=%0d num=%h valid=%b dp=%b err=%b tick=%b required cyc=%0d num=%h valid=%b dp=%b err=%b tick=%b",
                   cyc, num_out, num_valid, dp_out, pattern_err, frame_tick,
                   e.cyc, e.num, e.valid, e.dp, e.err, e.tick);
        end
      end
    end
    last = cur;
  end

  task automatic push(input int d, input logic [7:0] num, input logic [1:0] v,
                      input logic [1:0] dp, input logic err, input logic tick);
    obs_t o;
    o.cyc   = cyc + d;
    o.num   = num;
    o.valid = v;
    o.dp    = dp;
    o.err   = err;
    o.tick  = tick;
    sb.push_back(o);
  endtask

  task automatic drive(input logic [1:0] an, input logic [7:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h required=%h", name, got, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    an_in   = 2'b11;
    seg_in  = 8'hFF;
    err_clr = 1'b0;
    mon_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", outs, 14'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // digit0 shows 2 without dp, then with dp
    push(5, 8'h02, 2'b01, 2'b00, 1'b0, 1'b0);
    drive(2'b10, 8'h25, 6);
    push(5, 8'h02, 2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b10, 8'h24, 6);

    // ghost 1 for three samples, then 3 on digit1 completes a frame
    drive(2'b01, 8'h9F, 3);
    push(5, 8'h32, 2'b11, 2'b01, 1'b0, 1'b1);
    drive(2'b01, 8'h0D, 6);

    // scanning 7 / 9 with 5-cycle dwell
    push(5, 8'h37, 2'b11, 2'b00, 1'b0, 1'b0);
    drive(2'b10, 8'h1F, 5);
    push(5, 8'h97, 2'b11, 2'b00, 1'b0, 1'b1);
    drive(2'b01, 8'h19, 5);
    for (int r = 0; r < 2; r++) begin
      drive(2'b10, 8'h1F, 5);
      push(5, 8'h97, 2'b11, 2'b00, 1'b0, 1'b1);
      drive(2'b01, 8'h19, 5);
    end

    // illegal pattern sets the error, digits hold
    push(5, 8'h97, 2'b11, 2'b00, 1'b1, 1'b0);
    drive(2'b10, 8'hAA, 6);
    push(1, 8'h97, 2'b11, 2'b00, 1'b0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);

    // clear coincident with an illegal commit: set wins
    push(5, 8'h97, 2'b11, 2'b00, 1'b1, 1'b0);
    drive(2'b01, 8'hAA, 4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // idle and multi-select never commit
    drive(2'b11, 8'hAA, 20);
    drive(2'b00, 8'h1F, 20);
    check("idle_hold", outs, {8'h97, 2'b11, 2'b00, 1'b1, 1'b0});

    // blank with dp lit decodes as F
    push(5, 8'h9F, 2'b11, 2'b01, 1'b1, 1'b0);
    drive(2'b10, 8'hFE, 6);

    // reset with run count 3 drops the pending commit
    drive(2'b01, 8'h03, 4);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("reset_midrun", outs, 14'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(5, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    check("sb_drained", 14'(sb.size()), 14'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
